hazard_stall_unit: RTL and testbench

Pipeline interlock controller for the 5-stage KGP-RISC core. It produces the stall and flush controls that the forwarding path cannot resolve on its own:
- one-bubble insertion on load-use,
- IF/ID and ID/EX flush on a taken branch,
- whole-pipeline freeze while the data memory has not acknowledged an EX/MEM access, with a timeout.

It sits beside the forwarding logic in ID/EX and drives the pipeline-register write enables and the PC write enable.

---
 rtl/hazard_stall_unit.sv | 171 +++++++++++++++++
 tb/tb_hazard_stall_unit.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit
//   Pipeline interlock controller for the 5-stage KGP-RISC core. Generates
//   the stall / flush controls the forwarding path cannot resolve:
//   load-use bubble, taken-branch flush of IF/ID and ID/EX, and a whole-
//   pipeline freeze while data memory has not acknowledged an EX/MEM
//   access (with a timeout that raises mem_error for one cycle).
//
// Parameters
//   MEM_TIMEOUT : frozen cycles allowed before timeout (2..65535)
//   CNT_W       : performance counter width
//
// Ports
//   clk, rst_n                    clock, asynchronous active-low reset
//   if_id_rs/rt, if_id_uses_rt    ID-stage source registers
//   id_ex_rt, id_ex_memread       EX-stage load destination / load flag
//   branch_taken                  taken branch/jump resolved in EX
//   mem_req, mem_ack              data memory handshake for EX/MEM
//   pc_write, *_write             pipeline register write enables
//   id_ex_bubble, mem_wb_bubble   NOP insertion
//   if_id_flush, id_ex_flush      register clears on taken branch
//   mem_error                     one-cycle pulse on access timeout
//   stall_cycles, flush_count     performance counters
//
// Configuration
//   HAZARD_PERF_CNT_EN : when defined, builds saturating counters for
//   stall cycles and flushes; otherwise both outputs are tied to 0.

module hazard_stall_unit #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       if_id_rs,
    input  logic [4:0]       if_id_rt,
    input  logic             if_id_uses_rt,
    input  logic [4:0]       id_ex_rt,
    input  logic             id_ex_memread,
    input  logic             branch_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_write,
    output logic             ex_mem_write,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WCNT_W = $clog2(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEM_WAIT, TIMEOUT} state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              freeze;
    logic              load_use;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign freeze = (state_q == RUN && mem_req && !mem_ack) ||
                    (state_q == MEM_WAIT && !mem_ack);

    assign load_use = id_ex_memread && (id_ex_rt != 5'd0) &&
                      ((id_ex_rt == if_id_rs) ||
                       (if_id_uses_rt && id_ex_rt == if_id_rt));

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        id_ex_bubble  = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        mem_error     = 1'b0;

        // Next state
        unique case (state_q)
            RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (mem_ack) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_LAST) begin
                    state_d = TIMEOUT;
                    wcnt_d  = '0;
                end else begin
                    wcnt_d  = wcnt_q + WCNT_W'(1);
                end
            end
            TIMEOUT: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase

        // Outputs: freeze > branch > load-use > normal flow
        if (freeze) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_ex_write   = 1'b0;
            ex_mem_write  = 1'b0;
            mem_wb_bubble = 1'b1;
        end else begin
            if (branch_taken) begin
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (load_use && state_q != TIMEOUT) begin
                // TIMEOUT keeps every write enable high, so no stall there
                pc_write     = 1'b0;
                if_id_write  = 1'b0;
                id_ex_bubble = 1'b1;
            end
            if (state_q == TIMEOUT) begin
                // faulted access result is discarded on its way to WB
                mem_error     = 1'b1;
                mem_wb_bubble = 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if ((freeze || id_ex_bubble) && stall_q != '1)
                stall_q <= stall_q + CNT_W'(1);
            if (if_id_flush && flush_q != '1)
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
    assign flush_count  = flush_q;
`else
    assign stall_cycles = '0;
    assign flush_count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    localparam int CNT_W = 16;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // {pc, ifid, idex, exmem, id_ex_bubble, if_id_flush, id_ex_flush, mem_wb_bubble, mem_error}
    localparam logic [8:0] NORM = 9'b1111_000_00;
    localparam logic [8:0] LU   = 9'b0011_100_00;
    localparam logic [8:0] BR   = 9'b1111_011_00;
    localparam logic [8:0] FRZ  = 9'b0000_000_10;
    localparam logic [8:0] TOUT = 9'b1111_000_11;

    logic clk = 1'b0;
    logic rst_n;
    logic [4:0] if_id_rs, if_id_rt, id_ex_rt;
    logic if_id_uses_rt, id_ex_memread, branch_taken, mem_req, mem_ack;
    logic pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble;
    logic if_id_flush, id_ex_flush, mem_wb_bubble, mem_error;
    logic [CNT_W-1:0] stall_cycles, flush_count;

    int compared = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_id_rs(if_id_rs), .if_id_rt(if_id_rt), .if_id_uses_rt(if_id_uses_rt),
        .id_ex_rt(id_ex_rt), .id_ex_memread(id_ex_memread),
        .branch_taken(branch_taken), .mem_req(mem_req), .mem_ack(mem_ack),
        .pc_write(pc_write), .if_id_write(if_id_write), .id_ex_write(id_ex_write),
        .ex_mem_write(ex_mem_write), .id_ex_bubble(id_ex_bubble),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .mem_wb_bubble(mem_wb_bubble), .mem_error(mem_error),
        .stall_cycles(stall_cycles), .flush_count(flush_count)
    );

    typedef struct {
        string      name;
        logic [4:0] rs, rt, ex_rt;
        logic       uses_rt, memread, br, req, ack;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[10];

    function automatic logic [8:0] outs();
        return {pc_write, if_id_write, id_ex_write, ex_mem_write, id_ex_bubble,
                if_id_flush, id_ex_flush, mem_wb_bubble, mem_error};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        if_id_rs = '0; if_id_rt = '0; id_ex_rt = '0;
        if_id_uses_rt = 0; id_ex_memread = 0; branch_taken = 0;
        mem_req = 0; mem_ack = 0;
    endtask

    // Called at posedge+1; applies reset and releases it before the next edge
    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic chk_cnt(input string name, input int st, input int fl);
        chk({name, "_stall"}, 32'(stall_cycles), PERF ? 32'(st) : 32'd0);
        chk({name, "_flush"}, 32'(flush_count),  PERF ? 32'(fl) : 32'd0);
    endtask

    initial begin
        tbl[0] = '{"idle",       5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NORM};
        tbl[1] = '{"lu_rs",      5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, LU};
        tbl[2] = '{"lu_rt",      5'd1, 5'd7, 5'd7, 1, 1, 0, 0, 0, LU};
        tbl[3] = '{"rt_unused",  5'd1, 5'd7, 5'd7, 0, 1, 0, 0, 0, NORM};
        tbl[4] = '{"rt_zero",    5'd0, 5'd0, 5'd0, 1, 1, 0, 0, 0, NORM};
        tbl[5] = '{"no_load",    5'd5, 5'd0, 5'd5, 0, 0, 0, 0, 0, NORM};
        tbl[6] = '{"branch",     5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, BR};
        tbl[7] = '{"branch_lu",  5'd5, 5'd0, 5'd5, 0, 1, 1, 0, 0, BR};
        tbl[8] = '{"ack_no_req", 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, NORM};
        tbl[9] = '{"req_ack",    5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 1, NORM};

        idle_inputs();
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("reset_outs", 32'(outs()), 32'(NORM));
        chk_cnt("reset", 0, 0);
        rst_n = 1'b1;
        tick();

        // Single-cycle decisions in RUN; none of these leave RUN
        for (int i = 0; i < 10; i++) begin
            if_id_rs = tbl[i].rs; if_id_rt = tbl[i].rt; id_ex_rt = tbl[i].ex_rt;
            if_id_uses_rt = tbl[i].uses_rt; id_ex_memread = tbl[i].memread;
            branch_taken = tbl[i].br; mem_req = tbl[i].req; mem_ack = tbl[i].ack;
            #1;
            chk(tbl[i].name, 32'(outs()), 32'(tbl[i].exp));
            tick();
        end
        idle_inputs();
        #1;
        chk("post_table", 32'(outs()), 32'(NORM));

        // Ack after 3 cycles: 3 frozen cycles, advance on the ack cycle
        do_reset();
        mem_req = 1;
        for (int c = 0; c < 3; c++) begin
            #1; chk($sformatf("wait3_frz%0d", c), 32'(outs()), 32'(FRZ));
            tick();
        end
        mem_ack = 1;
        #1; chk("wait3_ack", 32'(outs()), 32'(NORM));
        tick();
        idle_inputs();
        #1; chk("wait3_after", 32'(outs()), 32'(NORM));
        chk_cnt("wait3", 3, 0);

        // Timeout with MEM_TIMEOUT=4: 4 frozen, 1 error cycle, back to RUN
        do_reset();
        mem_req = 1;
        for (int c = 0; c < 4; c++) begin
            #1; chk($sformatf("tout_frz%0d", c), 32'(outs()), 32'(FRZ));
            tick();
        end
        #1; chk("tout_err", 32'(outs()), 32'(TOUT));
        tick();
        mem_req = 0;
        #1; chk("tout_run", 32'(outs()), 32'(NORM));
        chk_cnt("tout", 4, 0);
        tick();

        // Async reset during MEM_WAIT
        do_reset();
        mem_req = 1;
        tick();
        tick();
        mem_req = 0;
        #1; chk("rst_mw_frozen", 32'(outs()), 32'(FRZ));
        rst_n = 1'b0;
        #1;
        chk("rst_mw_outs", 32'(outs()), 32'(NORM));
        chk_cnt("rst_mw", 0, 0);
        rst_n = 1'b1;
        tick();
        #1; chk("rst_mw_run", 32'(outs()), 32'(NORM));

        // Branch held through a 2-cycle freeze
        do_reset();
        mem_req = 1; branch_taken = 1;
        for (int c = 0; c < 2; c++) begin
            #1; chk($sformatf("brfrz_frz%0d", c), 32'(outs()), 32'(FRZ));
            tick();
        end
        mem_ack = 1;
        #1; chk("brfrz_release", 32'(outs()), 32'(BR));
        tick();
        idle_inputs();
        #1; chk("brfrz_after", 32'(outs()), 32'(NORM));
        chk_cnt("brfrz", 2, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 20000");
        $fatal(1);
    end

endmodule
